// File: rtl/vend_event_arbiter_if.sv
// Event stream handshake between the event arbiter (master) and the vending FSM (slave).
interface vend_event_arbiter_if;
    logic       evt_valid;
    logic       evt_ready;
    logic [2:0] evt_code;

    modport master (
        output evt_valid,
        output evt_code,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_code,
        output evt_ready
    );
endinterface

// File: rtl/vend_event_arbiter.sv
// vend_event_arbiter: folds the one-pulse button/coin events into one prioritized
// event stream (valid/ready through vend_event_arbiter_if) and owns the inactivity
// timer that raises the auto-refund timeout event.
// Optional feature: define VEND_ARB_DROP_CNT_EN to add a saturating drop_cnt[7:0] output.
module vend_event_arbiter #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 8192,
    parameter int TO_W    = 13
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           req,
    input  logic                 credit_nz,
    vend_event_arbiter_if.master evt,
    output logic                 busy,
    output logic                 drop
`ifdef VEND_ARB_DROP_CNT_EN
    ,
    output logic [7:0]           drop_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [2:0] CODE_CANCEL   = 3'd1;
    localparam logic [2:0] CODE_MONEY_5  = 3'd2;
    localparam logic [2:0] CODE_MONEY_10 = 3'd3;
    localparam logic [2:0] CODE_DRINK_A  = 3'd4;
    localparam logic [2:0] CODE_DRINK_B  = 3'd5;
    localparam logic [2:0] CODE_TIMEOUT  = 3'd6;

    typedef enum logic [1:0] {
        T_OFF,
        T_COUNT,
        T_FIRED
    } timer_state_t;

    logic [4:0]    pend;
    logic [4:0]    pend_next;
    logic          to_pend;
    logic          to_pend_next;
    logic [4:0]    grant_mask;
    logic          grant_to;
    logic [2:0]    grant_code;
    logic          drop_next;

    logic [2:0]    mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push;
    logic          can_grant;

    timer_state_t  t_state;
    timer_state_t  t_next;
    logic [TO_W-1:0] idle_cnt;
    logic [TO_W-1:0] idle_cnt_next;
    logic          fire;
    logic          idle;

    // FIFO status; a pop frees the slot the same cycle so a full FIFO can still accept a grant.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop       = !empty && evt.evt_ready;
    assign can_grant = !full || pop;
    assign push      = (grant_code != 3'd0);

    assign evt.evt_valid = !empty;
    assign evt.evt_code  = empty ? 3'd0 : mem[rd_ptr[AW-1:0]];
    assign busy          = (|pend) || to_pend || !empty;
    assign idle          = (req == 5'd0) && !busy;

    // Fixed-priority grant and next pending state; cancel also discards queued drink selections.
    always_comb begin
        grant_mask   = '0;
        grant_to     = 1'b0;
        grant_code   = 3'd0;
        if (can_grant) begin
            if (pend[0]) begin
                grant_mask[0] = 1'b1;
                grant_code    = CODE_CANCEL;
            end else if (to_pend) begin
                grant_to      = 1'b1;
                grant_code    = CODE_TIMEOUT;
            end else if (pend[2]) begin
                grant_mask[2] = 1'b1;
                grant_code    = CODE_MONEY_10;
            end else if (pend[1]) begin
                grant_mask[1] = 1'b1;
                grant_code    = CODE_MONEY_5;
            end else if (pend[3]) begin
                grant_mask[3] = 1'b1;
                grant_code    = CODE_DRINK_A;
            end else if (pend[4]) begin
                grant_mask[4] = 1'b1;
                grant_code    = CODE_DRINK_B;
            end
        end
        pend_next = pend & ~grant_mask;
        if (grant_mask[0]) begin
            pend_next[4:3] = 2'b00;
        end
        pend_next    = pend_next | req;
        drop_next    = |(req & pend & ~grant_mask);
        to_pend_next = (to_pend && !grant_to) || fire;
    end

    // Pending flags and the registered drop pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend    <= '0;
            to_pend <= 1'b0;
            drop    <= 1'b0;
        end else begin
            pend    <= pend_next;
            to_pend <= to_pend_next;
            drop    <= drop_next;
        end
    end

    // FIFO pointers; wrap-around is the natural overflow of the extra MSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // FIFO storage; contents are only visible while non-empty so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= grant_code;
        end
    end

    // Inactivity timer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_state  <= T_OFF;
            idle_cnt <= '0;
        end else begin
            t_state  <= t_next;
            idle_cnt <= idle_cnt_next;
        end
    end

    // Inactivity timer next state: count idle cycles with credit, fire once, rearm on a req.
    always_comb begin
        t_next        = t_state;
        idle_cnt_next = idle_cnt;
        fire          = 1'b0;
        case (t_state)
            T_OFF: begin
                idle_cnt_next = '0;
                if (credit_nz) begin
                    t_next = T_COUNT;
                end
            end
            T_COUNT: begin
                if (!credit_nz) begin
                    t_next        = T_OFF;
                    idle_cnt_next = '0;
                end else if (!idle) begin
                    idle_cnt_next = '0;
                end else if (idle_cnt == TO_W'(TIMEOUT - 1)) begin
                    fire          = 1'b1;
                    idle_cnt_next = '0;
                    t_next        = T_FIRED;
                end else begin
                    idle_cnt_next = idle_cnt + TO_W'(1);
                end
            end
            T_FIRED: begin
                idle_cnt_next = '0;
                if (!credit_nz) begin
                    t_next = T_OFF;
                end else if (req != 5'd0) begin
                    t_next = T_COUNT;
                end
            end
            default: begin
                t_next        = T_OFF;
                idle_cnt_next = '0;
            end
        endcase
    end

`ifdef VEND_ARB_DROP_CNT_EN
    // Saturating count of drop pulses, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (drop_next && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`endif

endmodule
